bar_to_steps: RTL
=================

// Module: bar_to_steps
// PURPOSE
//   Reads a WIDTH-bit thermometer (bar) code from asynchronous inputs such as switches or
//   a mirrored LED bar, and recovers the level it encodes. Synchronises, debounces and
//   validates the code, then steps an internal counter toward that level.
//   Emits one single-cycle up_pulse/down_pulse per step, the same pulse form as the
//   key edge-detector outputs that drive the up/down bar counter. It sits on the
//   opposite side of that counter: bar level in, step events out.
// PARAMETERS
//   WIDTH            7   bar width; encodable levels 0..WIDTH
//   DEBOUNCE_CYCLES  16  consecutive equal synced samples needed to accept a new bar (>=1)
//   STEP_GAP         4   idle cycles forced after each pulse (>=1); pulse period = STEP_GAP+1
//   CW = $clog2(WIDTH+1) (localparam, count width; 3 at defaults)
// PORTS
//   clk         in   1      system clock, all logic on rising edge
//   rst_n       in   1      asynchronous active-low reset
//   bar_in      in   WIDTH  asynchronous bar input; bit0 = lowest segment
//   count       out  CW     current tracked level
//   valid       out  1      last debounced bar was a legal thermometer code
//   err         out  1      last debounced bar was illegal (e.g. 0b0000101)
//   up_pulse    out  1      one-cycle step +1 event
//   down_pulse  out  1      one-cycle step -1 event
//   busy        out  1      count != target, or FSM not IDLE
// BEHAVIOUR
//   Reset (async, rst_n=0): sync regs, candidate, stable, debounce cnt, target, count,
//     gap cnt = 0; valid=0, err=0, up_pulse=down_pulse=0, busy=0, FSM=IDLE. All
//     outputs are registered. Reset asserted mid-operation aborts any stepping at once.
//   Sync: 2-flop synchroniser s1->s2 on bar_in.
//   Debounce: if s2!=cand then cand<=s2, dcnt<=0; else if dcnt==DEBOUNCE_CYCLES-1
//     then stable<=cand; else dcnt<=dcnt+1. A bouncing input never updates stable.
//   Decode (registered, every cycle):
//     - stable==(1<<k)-1 for some k in 0..WIDTH -> target<=k, valid<=1, err<=0.
//     - otherwise -> valid<=0, err<=1, target holds its last legal value.
//     valid=1 on the first edge after reset release (stable=0 is level 0).
//   Latency: take edge 0 as the first rising edge after bar_in settles.
//     stable updates at edge DEBOUNCE_CYCLES+2, target/valid/err at +3,
//     and the first pulse is registered at +4 (edge 20 at defaults).
//   Tracker FSM:
//     IDLE: count<target -> up_pulse<=1, count<=count+1, gcnt<=STEP_GAP, ->GAP
//           count>target -> down_pulse<=1, count<=count-1, gcnt<=STEP_GAP, ->GAP
//           equal -> stay.
//     GAP:  pulses 0; gcnt--; when gcnt reaches 1 -> IDLE.
//           The next pulse comes exactly STEP_GAP+1 cycles after the previous one.
//   Pulses: up_pulse and down_pulse are never high together, and never high on two
//     consecutive cycles. count changes on the same edge its pulse rises.
//   Target changes while stepping: the new target is sampled in the next IDLE, so
//     direction may reverse. A target change never truncates a GAP.
//   count stays within 0..WIDTH; no wrap-around is possible.
// TESTING
//   1 rst_n low 3 cycles, release, bar_in=0 -> valid=1 at first edge, count=0, no pulses ever.
//   2 bar_in 0->0b0000111 clean -> up_pulse at edges 20,25,30;
//     count=3; busy falls at edge 34 (GAP ends), no down_pulse.
//   3 bar_in bit0 toggles every 5 cycles for 40 cycles, then settles at 0b0000001
//     -> no pulse during bouncing; exactly one up_pulse, 20 edges after settling; count=1.
//   4 from level 3, bar_in=0b0000101 -> err=1, valid=0 at edge 19, no pulses, count=3;
//     then 0b0000011 -> err=0 and exactly one down_pulse; count=2.
//   5 level 7; bar_in=0; after 3 down_pulses set bar_in=0b1111111
//     -> pulses continue down until the new target registers, then up; final count=7.
//     Check pulse spacing is exactly 5 throughout.
//   6 rst_n low mid-stepping (count=4, target=7) -> all outputs 0 immediately.
//     After release with bar_in=0b1111111 -> 7 up_pulses starting at edge 20.

Source files
------------

// File: rtl/bar_to_steps.sv
// bar_to_steps: recovers the level encoded by an asynchronous thermometer (bar)
// input and emits one single-cycle up/down step pulse per unit of level change.
// Pipeline: 2-flop sync -> debounce -> registered decode -> pulse-paced tracker.
module bar_to_steps #(
    parameter  int WIDTH           = 7,
    parameter  int DEBOUNCE_CYCLES = 16,
    parameter  int STEP_GAP        = 4,
    localparam int CW              = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] bar_in,
    output logic [CW-1:0]    count,
    output logic             valid,
    output logic             err,
    output logic             up_pulse,
    output logic             down_pulse,
    output logic             busy
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int GW = $clog2(STEP_GAP + 1);

    typedef enum logic {
        IDLE,
        GAP
    } state_t;

    // Thermometer code holding the lowest k segments lit.
    function automatic logic [WIDTH-1:0] thermo(input int k);
        logic [WIDTH-1:0] t;
        for (int i = 0; i < WIDTH; i++) begin
            t[i] = (i < k);
        end
        return t;
    endfunction

    logic [WIDTH-1:0] s1_q, s2_q;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic [CW-1:0]    target_q, target_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             legal;
    logic [CW-1:0]    level;
    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [GW-1:0]    gcnt_q, gcnt_d;
    logic             up_q, up_d;
    logic             down_q, down_d;
    logic             busy_q, busy_d;

    // Two-flop synchroniser on the asynchronous bar input.
    // NOTE: clocked blocks use non-blocking (<=) so every flop samples the
    // pre-edge value of its source; blocking here would collapse s1/s2 into one stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= bar_in;
            s2_q <= s1_q;
        end
    end

    // Debounce: accept the candidate only after it has been seen unchanged long enough.
    // NOTE: every variable driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        cand_d   = cand_q;
        dcnt_d   = dcnt_q;
        stable_d = stable_q;
        if (s2_q != cand_q) begin
            cand_d = s2_q;
            dcnt_d = '0;
        end else if (dcnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = cand_q;
        end else begin
            dcnt_d = dcnt_q + DW'(1);
        end
    end

    // Decode: a legal bar is exactly the lowest k segments lit; report its level.
    always_comb begin
        legal = 1'b0;
        level = '0;
        for (int k = 0; k <= WIDTH; k++) begin
            if (stable_q == thermo(k)) begin
                legal = 1'b1;
                level = CW'(k);
            end
        end
        valid_d  = legal;
        err_d    = !legal;
        target_d = legal ? level : target_q;
    end

    // Tracker: one step toward target per visit to IDLE, then a fixed idle gap.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        gcnt_d  = gcnt_q;
        up_d    = 1'b0;
        down_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q < target_q) begin
                    up_d    = 1'b1;
                    count_d = count_q + CW'(1);
                    gcnt_d  = GW'(STEP_GAP);
                    state_d = GAP;
                end else if (count_q > target_q) begin
                    down_d  = 1'b1;
                    count_d = count_q - CW'(1);
                    gcnt_d  = GW'(STEP_GAP);
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gcnt_q == GW'(1)) begin
                    gcnt_d  = '0;
                    state_d = IDLE;
                end else begin
                    gcnt_d = gcnt_q - GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Busy is registered, so it is derived from the values about to be stored.
        busy_d = (count_d != target_d) || (state_d != IDLE);
    end

    // State register for debounce, decode and tracker; reset aborts any stepping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q   <= '0;
            dcnt_q   <= '0;
            stable_q <= '0;
            target_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            state_q  <= IDLE;
            count_q  <= '0;
            gcnt_q   <= '0;
            up_q     <= 1'b0;
            down_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            cand_q   <= cand_d;
            dcnt_q   <= dcnt_d;
            stable_q <= stable_d;
            target_q <= target_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            state_q  <= state_d;
            count_q  <= count_d;
            gcnt_q   <= gcnt_d;
            up_q     <= up_d;
            down_q   <= down_d;
            busy_q   <= busy_d;
        end
    end

    assign count      = count_q;
    assign valid      = valid_q;
    assign err        = err_q;
    assign up_pulse   = up_q;
    assign down_pulse = down_q;
    assign busy       = busy_q;

endmodule
